// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register: STAGES slices with stall hold, flush-to-bubble, x0 write squash and a bubble counter.
// Latency is STAGES advancing cycles; StallM freezes every slice, and FlushM overrides it and empties the whole chain.
module ex_mem_pipe_reg #(
    parameter int XLEN      = 32,
    parameter int STAGES    = 1,
    parameter int SQUASH_X0 = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallM,
    input  logic             FlushM,
    input  logic             CntClr,
    input  logic             ValidE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic [2:0]       funct3E,
    input  logic [XLEN-1:0]  ALUResult,
    input  logic [XLEN-1:0]  WriteDataE,
    input  logic [XLEN-1:0]  PCPlus4E,
    input  logic [4:0]       RdE,
    output logic             ValidM,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [2:0]       funct3M,
    output logic [XLEN-1:0]  ALUResultM,
    output logic [XLEN-1:0]  WriteDataM,
    output logic [XLEN-1:0]  PCPlus4M,
    output logic [4:0]       RdM,
    output logic [CNT_W-1:0] BubbleCount
);
    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic [1:0]      resultsrc;
        logic [2:0]      funct3;
        logic [XLEN-1:0] aluresult;
        logic [XLEN-1:0] writedata;
        logic [XLEN-1:0] pcplus4;
        logic [4:0]      rd;
    } slice_t;

    slice_t           entry;
    slice_t           pipe [STAGES];
    slice_t           last;
    logic [CNT_W-1:0] bubble_cnt;

    // An invalid EX slot enters as an all-zero bubble so no stale field can leak into MEM.
    always_comb begin
        entry = '0;
        if (ValidE) begin
            entry.valid     = 1'b1;
            entry.regwrite  = RegWriteE;
            entry.memwrite  = MemWriteE;
            entry.resultsrc = ResultSrcE;
            entry.funct3    = funct3E;
            entry.aluresult = ALUResult;
            entry.writedata = WriteDataE;
            entry.pcplus4   = PCPlus4E;
            entry.rd        = RdE;
            if (SQUASH_X0 != 0 && RdE == 5'd0) begin
                entry.regwrite = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || FlushM) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else if (!StallM) begin
            pipe[0] <= entry;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign last = pipe[STAGES-1];

    // Counts MEM advancing with an empty slot; a flush edge counts only if MEM was already empty.
    always_ff @(posedge clk) begin
        if (rst || CntClr) begin
            bubble_cnt <= '0;
        end else if (!StallM && !last.valid && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign ValidM      = last.valid;
    assign RegWriteM   = last.regwrite;
    assign MemWriteM   = last.memwrite;
    assign ResultSrcM  = last.resultsrc;
    assign funct3M     = last.funct3;
    assign ALUResultM  = last.aluresult;
    assign WriteDataM  = last.writedata;
    assign PCPlus4M    = last.pcplus4;
    assign RdM         = last.rd;
    assign BubbleCount = bubble_cnt;
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: three instances (1 slice/3-bit counter, 3 slices, 1 slice without x0 squash) share one stimulus.
module tb_ex_mem_pipe_reg;
    logic        clk = 1'b0;
    logic        rst, StallM, FlushM, CntClr;
    logic        ValidE, RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  funct3E;
    logic [31:0] ALUResult, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;

    logic a_ValidM, a_RegWriteM, a_MemWriteM;
    logic [1:0] a_ResultSrcM;
    logic [2:0] a_funct3M;
    logic [31:0] a_ALUResultM, a_WriteDataM, a_PCPlus4M;
    logic [4:0] a_RdM;
    logic [2:0] a_BubbleCount;

    logic b_ValidM, b_RegWriteM, b_MemWriteM;
    logic [1:0] b_ResultSrcM;
    logic [2:0] b_funct3M;
    logic [31:0] b_ALUResultM, b_WriteDataM, b_PCPlus4M;
    logic [4:0] b_RdM;
    logic [15:0] b_BubbleCount;

    logic c_ValidM, c_RegWriteM, c_MemWriteM;
    logic [1:0] c_ResultSrcM;
    logic [2:0] c_funct3M;
    logic [31:0] c_ALUResultM, c_WriteDataM, c_PCPlus4M;
    logic [4:0] c_RdM;
    logic [15:0] c_BubbleCount;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] alu;
        int          due;
    } sb_t;

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.XLEN(32), .STAGES(1), .SQUASH_X0(1), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM), .CntClr(CntClr),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .funct3E(funct3E), .ALUResult(ALUResult), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ValidM(a_ValidM), .RegWriteM(a_RegWriteM), .MemWriteM(a_MemWriteM), .ResultSrcM(a_ResultSrcM),
        .funct3M(a_funct3M), .ALUResultM(a_ALUResultM), .WriteDataM(a_WriteDataM), .PCPlus4M(a_PCPlus4M),
        .RdM(a_RdM), .BubbleCount(a_BubbleCount));

    ex_mem_pipe_reg #(.XLEN(32), .STAGES(3), .SQUASH_X0(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM), .CntClr(CntClr),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .funct3E(funct3E), .ALUResult(ALUResult), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ValidM(b_ValidM), .RegWriteM(b_RegWriteM), .MemWriteM(b_MemWriteM), .ResultSrcM(b_ResultSrcM),
        .funct3M(b_funct3M), .ALUResultM(b_ALUResultM), .WriteDataM(b_WriteDataM), .PCPlus4M(b_PCPlus4M),
        .RdM(b_RdM), .BubbleCount(b_BubbleCount));

    ex_mem_pipe_reg #(.XLEN(32), .STAGES(1), .SQUASH_X0(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM), .CntClr(CntClr),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .funct3E(funct3E), .ALUResult(ALUResult), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ValidM(c_ValidM), .RegWriteM(c_RegWriteM), .MemWriteM(c_MemWriteM), .ResultSrcM(c_ResultSrcM),
        .funct3M(c_funct3M), .ALUResultM(c_ALUResultM), .WriteDataM(c_WriteDataM), .PCPlus4M(c_PCPlus4M),
        .RdM(c_RdM), .BubbleCount(c_BubbleCount));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        StallM = 1'b0; FlushM = 1'b0; CntClr = 1'b0;
        ValidE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 2'd0; funct3E = 3'd0;
        ALUResult = 32'd0; WriteDataE = 32'd0; PCPlus4E = 32'd0; RdE = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        ValidE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'd3; funct3E = 3'd7;
        ALUResult = 32'hFFFF_FFFF; WriteDataE = 32'hAAAA_5555; PCPlus4E = 32'h0000_1004; RdE = 5'd5;
        for (int e = 1; e <= 2; e++) begin
            step();
            checks++;
            if ({a_ValidM, a_RegWriteM, a_MemWriteM, a_ResultSrcM, a_funct3M, a_ALUResultM,
                 a_WriteDataM, a_PCPlus4M, a_RdM, a_BubbleCount} !== '0) begin
                failures++;
                $display("FAIL reset_a edge %0d: valid=%b rw=%b mw=%b rs=%h f3=%h alu=%h rd=%h cnt=%h, required all 0",
                         e, a_ValidM, a_RegWriteM, a_MemWriteM, a_ResultSrcM, a_funct3M, a_ALUResultM, a_RdM, a_BubbleCount);
            end
            checks++;
            if ({b_ValidM, b_RegWriteM, b_MemWriteM, b_ResultSrcM, b_funct3M, b_ALUResultM,
                 b_WriteDataM, b_PCPlus4M, b_RdM, b_BubbleCount} !== '0) begin
                failures++;
                $display("FAIL reset_b edge %0d: valid=%b alu=%h f3=%h cnt=%h, required all 0",
                         e, b_ValidM, b_ALUResultM, b_funct3M, b_BubbleCount);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        idle_inputs();
        ValidE = 1'b1; RdE = 5'd5; RegWriteE = 1'b1; ALUResult = 32'h1234; funct3E = 3'b010;
        ResultSrcE = 2'd1; WriteDataE = 32'h55; PCPlus4E = 32'h104;
        step();
        checks++;
        if (a_ValidM !== 1'b1 || a_RdM !== 5'd5 || a_RegWriteM !== 1'b1 || a_ALUResultM !== 32'h1234 ||
            a_funct3M !== 3'd2 || a_ResultSrcM !== 2'd1 || a_WriteDataM !== 32'h55 ||
            a_PCPlus4M !== 32'h104 || a_MemWriteM !== 1'b0) begin
            failures++;
            $display("FAIL pass_through: valid=%b rd=%0d rw=%b alu=%h f3=%0d rs=%0d wd=%h pc4=%h mw=%b, required 1 5 1 1234 2 1 55 104 0",
                     a_ValidM, a_RdM, a_RegWriteM, a_ALUResultM, a_funct3M, a_ResultSrcM, a_WriteDataM, a_PCPlus4M, a_MemWriteM);
        end
        checks++;
        if (a_BubbleCount !== 3'd1) begin
            failures++;
            $display("FAIL pass_count_first: BubbleCount=%0d, required 1", a_BubbleCount);
        end
        idle_inputs();
        step();
        checks++;
        if (a_ValidM !== 1'b0 || a_BubbleCount !== 3'd1) begin
            failures++;
            $display("FAIL pass_after_valid: ValidM=%b BubbleCount=%0d, required 0 1", a_ValidM, a_BubbleCount);
        end
    endtask

    task automatic test_latency();
        sb_t q[$];
        int adv = 0;
        int bub = 0;
        logic exp_v = 1'b0;
        logic [31:0] exp_alu = '0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            idle_inputs();
            if (k < 3) begin
                ValidE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7;
                ALUResult = 32'hA + 32'(k);
                q.push_back('{ALUResult, adv + 3});
            end
            if (!exp_v) bub++;
            adv++;
            exp_v = 1'b0; exp_alu = '0;
            if (q.size() > 0 && q[0].due == adv) begin
                exp_v = 1'b1; exp_alu = q[0].alu;
                void'(q.pop_front());
            end
            step();
            checks++;
            if (b_ValidM !== exp_v || b_ALUResultM !== exp_alu || b_BubbleCount !== 16'(bub)) begin
                failures++;
                $display("FAIL latency edge %0d: ValidM=%b ALUResultM=%h BubbleCount=%0d, required %b %h %0d",
                         k + 1, b_ValidM, b_ALUResultM, b_BubbleCount, exp_v, exp_alu, bub);
            end
        end
    endtask

    task automatic test_stall();
        sb_t q[$];
        int adv = 0;
        int bub = 0;
        logic exp_v = 1'b0;
        logic [31:0] exp_alu = '0;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            logic stall;
            stall = (k == 4 || k == 5);
            idle_inputs();
            StallM = stall;
            if (k < 7) begin
                ValidE = 1'b1; RegWriteE = 1'b1; RdE = 5'd2;
                ALUResult = stall ? (32'hDEAD_0000 + 32'(k)) : (k < 4 ? 32'h10 + 32'(k) : 32'h14);
                if (!stall) q.push_back('{ALUResult, adv + 3});
            end
            if (!stall) begin
                if (!exp_v) bub++;
                adv++;
                exp_v = 1'b0; exp_alu = '0;
                if (q.size() > 0 && q[0].due == adv) begin
                    exp_v = 1'b1; exp_alu = q[0].alu;
                    void'(q.pop_front());
                end
            end
            step();
            checks++;
            if (b_ValidM !== exp_v || b_ALUResultM !== exp_alu || b_BubbleCount !== 16'(bub)) begin
                failures++;
                $display("FAIL stall edge %0d (stall=%b): ValidM=%b ALUResultM=%h BubbleCount=%0d, required %b %h %0d",
                         k + 1, stall, b_ValidM, b_ALUResultM, b_BubbleCount, exp_v, exp_alu, bub);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        ValidE = 1'b1; MemWriteE = 1'b1; RegWriteE = 1'b1; RdE = 5'd9; ALUResult = 32'h400;
        step();
        checks++;
        if (a_ValidM !== 1'b1 || a_MemWriteM !== 1'b1 || a_BubbleCount !== 3'd1) begin
            failures++;
            $display("FAIL flush_setup: ValidM=%b MemWriteM=%b BubbleCount=%0d, required 1 1 1", a_ValidM, a_MemWriteM, a_BubbleCount);
        end
        StallM = 1'b1; FlushM = 1'b1;
        step();
        checks++;
        if (a_ValidM !== 1'b0 || a_MemWriteM !== 1'b0 || a_RegWriteM !== 1'b0 || a_RdM !== 5'd0 || a_BubbleCount !== 3'd1) begin
            failures++;
            $display("FAIL flush_over_stall: ValidM=%b MemWriteM=%b RegWriteM=%b RdM=%0d BubbleCount=%0d, required 0 0 0 0 1",
                     a_ValidM, a_MemWriteM, a_RegWriteM, a_RdM, a_BubbleCount);
        end
        for (int e = 3; e <= 6; e++) begin
            idle_inputs();
            if (e == 4) begin
                ValidE = 1'b1; MemWriteE = 1'b1; RdE = 5'd3;
            end
            if (e >= 5) begin
                FlushM = 1'b1; ValidE = 1'b1; MemWriteE = 1'b1; RdE = 5'd4;
            end
            step();
            checks++;
            if (b_ValidM !== 1'b0 || b_MemWriteM !== 1'b0) begin
                failures++;
                $display("FAIL flush_inner_slices edge %0d: b ValidM=%b MemWriteM=%b, required 0 0", e, b_ValidM, b_MemWriteM);
            end
            checks++;
            if (a_ValidM !== (e == 4) || a_BubbleCount !== ((e == 3) ? 3'd2 : (e == 6) ? 3'd4 : 3'd3)) begin
                failures++;
                $display("FAIL flush_count edge %0d: ValidM=%b BubbleCount=%0d, required %b %0d", e, a_ValidM, a_BubbleCount,
                         (e == 4), ((e == 3) ? 2 : (e == 6) ? 4 : 3));
            end
        end
    endtask

    task automatic test_squash();
        do_reset();
        ValidE = 1'b1; RdE = 5'd0; RegWriteE = 1'b1; ALUResult = 32'h77;
        step();
        checks++;
        if (a_RegWriteM !== 1'b0 || a_ValidM !== 1'b1 || a_ALUResultM !== 32'h77) begin
            failures++;
            $display("FAIL squash_x0: RegWriteM=%b ValidM=%b ALUResultM=%h, required 0 1 77", a_RegWriteM, a_ValidM, a_ALUResultM);
        end
        checks++;
        if (c_RegWriteM !== 1'b1 || c_RdM !== 5'd0) begin
            failures++;
            $display("FAIL no_squash_x0: RegWriteM=%b RdM=%0d, required 1 0", c_RegWriteM, c_RdM);
        end
        RdE = 5'd3;
        step();
        checks++;
        if (a_RegWriteM !== 1'b1 || a_RdM !== 5'd3) begin
            failures++;
            $display("FAIL squash_nonzero_rd: RegWriteM=%b RdM=%0d, required 1 3", a_RegWriteM, a_RdM);
        end
        ValidE = 1'b0; MemWriteE = 1'b1; RegWriteE = 1'b1; RdE = 5'd4; ALUResult = 32'h99;
        step();
        checks++;
        if (a_MemWriteM !== 1'b0 || a_RegWriteM !== 1'b0 || a_RdM !== 5'd0 || a_ALUResultM !== 32'd0 || c_MemWriteM !== 1'b0) begin
            failures++;
            $display("FAIL invalid_entry: MemWriteM=%b RegWriteM=%b RdM=%0d ALUResultM=%h cMemWriteM=%b, required 0 0 0 0 0",
                     a_MemWriteM, a_RegWriteM, a_RdM, a_ALUResultM, c_MemWriteM);
        end
    endtask

    task automatic test_counter();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (a_BubbleCount !== 3'((i > 7) ? 7 : i)) begin
                failures++;
                $display("FAIL counter_sat edge %0d: BubbleCount=%0d, required %0d", i, a_BubbleCount, (i > 7) ? 7 : i);
            end
        end
        CntClr = 1'b1;
        step();
        checks++;
        if (a_BubbleCount !== 3'd0) begin
            failures++;
            $display("FAIL counter_clr_on_bubble: BubbleCount=%0d, required 0", a_BubbleCount);
        end
        CntClr = 1'b0;
        step();
        checks++;
        if (a_BubbleCount !== 3'd1) begin
            failures++;
            $display("FAIL counter_after_clr: BubbleCount=%0d, required 1", a_BubbleCount);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_pass_through();
        test_latency();
        test_stall();
        test_flush();
        test_squash();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion before 100000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
